fp_convert_seq: RTL and testbench

- Parametrised, multi-cycle successor to the combinational floating-point converter.
- Accepts an IN_W-bit two's-complement sample over a valid/ready handshake and produces a sign / EXP_W-bit exponent / MAN_W-bit significand encoding with round-to-nearest.
- Normalises iteratively, one left shift per clock, and holds the result until the consumer accepts it.
- Sits between the sample source and the display/encode stage.

---
 rtl/fp_convert_if.sv | 27 ++
 rtl/fp_convert_seq.sv | 121 ++++++++++++
 tb/tb_fp_convert_seq.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/fp_convert_if.sv
// Handshake bundle between the sample source, the float converter and the encode stage.
// The source drives the input side and the consumer drives out_ready.
interface fp_convert_if #(
  parameter int IN_W  = 12,
  parameter int EXP_W = 3,
  parameter int MAN_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  d;
  logic             out_valid;
  logic             out_ready;
  logic             s;
  logic [EXP_W-1:0] e;
  logic [MAN_W-1:0] f;
  logic             sat;

  modport master (
    output in_valid, d, out_ready,
    input  in_ready, out_valid, s, e, f, sat
  );

  modport slave (
    input  in_valid, d, out_ready,
    output in_ready, out_valid, s, e, f, sat
  );
endinterface

// File: rtl/fp_convert_seq.sv
// Sequential two's-complement to sign/exponent/significand converter.
// It normalises one bit per clock and rounds to nearest.
//  state | meaning
//  IDLE  | waiting for a sample (in_ready high)
//  NORM  | shifting the magnitude left until its MSB is set or the exponent is 0
//  ROUND | rounding the top bits and loading s/e/f/sat
//  PACK  | raising out_valid one cycle after the result is loaded
//  DONE  | holding the result until out_ready
module fp_convert_seq #(
  parameter int IN_W  = 12,
  parameter int EXP_W = 3,
  parameter int MAN_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  fp_convert_if.slave bus
);
  localparam int EMAX = IN_W - MAN_W - 1;
  localparam logic [EXP_W-1:0] EMAX_E = EXP_W'(EMAX);

  typedef enum logic [2:0] {IDLE, NORM, ROUND, PACK, DONE} state_t;

  state_t           state;
  logic [IN_W-2:0]  mag;
  logic [EXP_W-1:0] exp_r;
  logic             s_reg;
  logic             sat_reg;
  logic             out_valid_r;
  logic             s_r;
  logic [EXP_W-1:0] e_r;
  logic [MAN_W-1:0] f_r;
  logic             sat_r;

  logic [IN_W-1:0]  d_neg;
  logic             d_is_min;
  logic [IN_W-2:0]  d_mag;
  logic [MAN_W-1:0] fr;
  logic             rb;

  assign d_neg    = -bus.d;
  assign d_is_min = (bus.d == {1'b1, {(IN_W-1){1'b0}}});
  assign d_mag    = d_is_min ? {(IN_W-1){1'b1}}
                  : (bus.d[IN_W-1] ? d_neg[IN_W-2:0] : bus.d[IN_W-2:0]);
  assign fr       = mag[IN_W-2 -: MAN_W];
  assign rb       = mag[IN_W-2-MAN_W];

  assign bus.in_ready  = (state == IDLE) & ~rst;
  assign bus.out_valid = out_valid_r;
  assign bus.s         = s_r;
  assign bus.e         = e_r;
  assign bus.f         = f_r;
  assign bus.sat       = sat_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      mag         <= '0;
      exp_r       <= '0;
      s_reg       <= 1'b0;
      sat_reg     <= 1'b0;
      out_valid_r <= 1'b0;
      s_r         <= 1'b0;
      e_r         <= '0;
      f_r         <= '0;
      sat_r       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            s_reg   <= bus.d[IN_W-1];
            mag     <= d_mag;
            sat_reg <= d_is_min;
            exp_r   <= EMAX_E;
            state   <= NORM;
          end
        end
        NORM: begin
          if (exp_r == '0 || mag[IN_W-2]) begin
            state <= ROUND;
          end else begin
            mag   <= mag << 1;
            exp_r <= exp_r - EXP_W'(1);
          end
        end
        ROUND: begin
          s_r <= s_reg;
          // A round-up of an all-ones fraction carries into the exponent unless already at EMAX.
          if (!rb) begin
            f_r   <= fr;
            e_r   <= exp_r;
            sat_r <= sat_reg;
          end else if (!(&fr)) begin
            f_r   <= fr + MAN_W'(1);
            e_r   <= exp_r;
            sat_r <= sat_reg;
          end else if (exp_r != EMAX_E) begin
            f_r   <= {1'b1, {(MAN_W-1){1'b0}}};
            e_r   <= exp_r + EXP_W'(1);
            sat_r <= sat_reg;
          end else begin
            f_r   <= '1;
            e_r   <= EMAX_E;
            sat_r <= 1'b1;
          end
          state <= PACK;
        end
        PACK: begin
          out_valid_r <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_convert_seq.sv
// Self-checking bench for fp_convert_seq: directed vectors, backpressure and reset
// sequences, then random samples against an arithmetic reference model.
module tb_fp_convert_seq;
  localparam int IN_W  = 12;
  localparam int EXP_W = 3;
  localparam int MAN_W = 4;
  localparam int EMAX  = IN_W - MAN_W - 1;
  localparam int LIMIT = 40;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  fp_convert_if #(.IN_W(IN_W), .EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();

  fp_convert_seq #(.IN_W(IN_W), .EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [IN_W-1:0] d;
    logic            s;
    int              e;
    int              f;
    logic            sat;
    int              lat;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: shift count is the leading-zero count capped at EMAX; round half up.
  task automatic model(input logic [IN_W-1:0] din, output logic s, output int e,
                       output int f, output logic sat, output int lat);
    int v, m, k, unit, q;
    v   = int'($signed(din));
    s   = din[IN_W-1];
    sat = 1'b0;
    m   = (v < 0) ? -v : v;
    if (m > (2**(IN_W-1)) - 1) begin
      m   = (2**(IN_W-1)) - 1;
      sat = 1'b1;
    end
    k = 0;
    while (k < EMAX && m * (2**k) < 2**(IN_W-2)) k++;
    unit = 2**(IN_W-1-MAN_W);
    q    = (m * (2**k) + unit / 2) / unit;
    e    = EMAX - k;
    if (q == 2**MAN_W) begin
      if (e < EMAX) begin
        q = 2**(MAN_W-1);
        e = e + 1;
      end else begin
        q   = 2**MAN_W - 1;
        sat = 1'b1;
      end
    end
    f   = q;
    lat = k + 3;
  endtask

  // Accepts one sample and waits for out_valid; does not acknowledge it.
  task automatic start_and_wait(input logic [IN_W-1:0] din, output int lat, output logic ok);
    int n;
    n = 0;
    while (!bus.in_ready && n < LIMIT) begin
      tick();
      n++;
    end
    bus.d        = din;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < LIMIT) begin
      tick();
      lat++;
    end
    ok = bus.out_valid;
    if (!ok) chk("timeout", 0, 1);
  endtask

  task automatic ack();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  vec_t vecs[7];

  initial begin
    int   lat;
    logic ok;
    logic ms, msat;
    int   me, mf, mlat;
    logic [IN_W-1:0] rd;
    logic            hs;
    int              he, hf;

    checks = 0;
    failures = 0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.d         = '0;
    rst = 1'b1;

    vecs[0] = '{12'h02E, 1'b0, 2, 12, 1'b0, 8};
    vecs[1] = '{12'hFD2, 1'b1, 2, 12, 1'b0, 8};
    vecs[2] = '{12'h07D, 1'b0, 4,  8, 1'b0, 7};
    vecs[3] = '{12'h7FF, 1'b0, 7, 15, 1'b1, 3};
    vecs[4] = '{12'h800, 1'b1, 7, 15, 1'b1, 3};
    vecs[5] = '{12'h005, 1'b0, 0,  5, 1'b0, 10};
    vecs[6] = '{12'h000, 1'b0, 0,  0, 1'b0, 10};

    tick();
    tick();
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_in_ready", int'(bus.in_ready), 0);
    chk("rst_e", int'(bus.e), 0);
    chk("rst_f", int'(bus.f), 0);
    chk("rst_sat", int'(bus.sat), 0);
    rst = 1'b0;
    tick();
    chk("idle_in_ready", int'(bus.in_ready), 1);

    for (int i = 0; i < 7; i++) begin
      start_and_wait(vecs[i].d, lat, ok);
      if (ok) begin
        chk($sformatf("v%0d_s", i), int'(bus.s), int'(vecs[i].s));
        chk($sformatf("v%0d_e", i), int'(bus.e), vecs[i].e);
        chk($sformatf("v%0d_f", i), int'(bus.f), vecs[i].f);
        chk($sformatf("v%0d_sat", i), int'(bus.sat), int'(vecs[i].sat));
        chk($sformatf("v%0d_lat", i), lat, vecs[i].lat);
      end
      ack();
    end

    // Backpressure: result must hold and a stray in_valid must be ignored.
    start_and_wait(12'h02E, lat, ok);
    hs = 1'b0; he = 2; hf = 12;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        bus.d        = 12'h7FF;
        bus.in_valid = 1'b1;
      end
      tick();
      bus.in_valid = 1'b0;
      chk("bp_valid", int'(bus.out_valid), 1);
      chk("bp_in_ready", int'(bus.in_ready), 0);
      chk("bp_s", int'(bus.s), int'(hs));
      chk("bp_e", int'(bus.e), he);
      chk("bp_f", int'(bus.f), hf);
    end
    ack();
    chk("bp_release_valid", int'(bus.out_valid), 0);
    chk("bp_release_ready", int'(bus.in_ready), 1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("bp_no_ghost", int'(bus.out_valid), 0);
    end

    // Reset in the middle of normalisation.
    bus.d        = 12'h001;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", int'(bus.out_valid), 0);
    chk("mid_rst_in_ready", int'(bus.in_ready), 0);
    chk("mid_rst_e", int'(bus.e), 0);
    chk("mid_rst_f", int'(bus.f), 0);
    chk("mid_rst_sat", int'(bus.sat), 0);
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", int'(bus.in_ready), 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("post_rst_quiet", int'(bus.out_valid), 0);
    end
    start_and_wait(12'h02E, lat, ok);
    if (ok) begin
      chk("post_rst_e", int'(bus.e), 2);
      chk("post_rst_f", int'(bus.f), 12);
      chk("post_rst_lat", lat, 8);
    end
    ack();

    // Random samples with random consumer stall.
    for (int i = 0; i < 200; i++) begin
      rd = IN_W'($urandom);
      if (i % 10 == 0) rd = IN_W'($urandom_range(0, 31));
      model(rd, ms, me, mf, msat, mlat);
      start_and_wait(rd, lat, ok);
      if (ok) begin
        repeat ($urandom_range(0, 3)) tick();
        chk("rnd_s", int'(bus.s), int'(ms));
        chk("rnd_e", int'(bus.e), me);
        chk("rnd_f", int'(bus.f), mf);
        chk("rnd_sat", int'(bus.sat), int'(msat));
        chk("rnd_lat", lat, mlat);
      end
      ack();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
